// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for an N-digit common-anode 7-segment display.
//   A hex value is captured into a pending buffer and committed to the active
//   buffer only at the end of a scan frame, so a frame never mixes old and
//   new content. Each digit slot lasts REFRESH_DIV clocks; the first clock of
//   every slot (except the very first slot after reset) is a guard interval
//   with all anodes off to suppress ghosting.
//
// Ports
//   clk_i       system clock
//   rst_i       asynchronous, active-high reset
//   data_i      hex value, data_i[3:0] = digit 0 (rightmost)
//   dp_i        decimal-point enables, bit i = digit i
//   load_i      capture strobe for data_i/dp_i
//   blank_lz_i  leading-zero blanking enable
//   en_i        display enable (0 = everything off, scan keeps running)
//   seg_o       segments {g,f,e,d,c,b,a}
//   dp_o        decimal point of the digit currently driven
//   an_o        one-hot digit enable, bit i = digit i
//   frame_o     one-cycle pulse when the scan wraps to digit 0
//   pending_o   loaded data waiting for the next frame commit
//
// Load semantics: load_i is a plain strobe without back-pressure; every cycle
// it is high is accepted and the last load before a commit wins.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  input  logic                  en_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o,
  output logic                  pending_o
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PS_W  = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(REFRESH_DIV - 1);
  // Output polarity: all internal levels are active-high, flipped at the pins.
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PS_W-1:0]       ps_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  guard_q;
  logic [4*N_DIGITS-1:0] act_data_q;
  logic [N_DIGITS-1:0]   act_dp_q;
  logic [4*N_DIGITS-1:0] pend_data_q;
  logic [N_DIGITS-1:0]   pend_dp_q;
  logic                  pend_flag_q;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   an_q;
  logic                  frame_q;

  logic                  tick;
  logic                  commit;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h67;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick   = (ps_q == LAST_PS);
  // The slot of the last digit ending is the frame boundary.
  assign commit = tick && (idx_q == LAST_IDX);

  // -------------------------------------------------------------------------
  // Scan counters and buffers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ps_q        <= '0;
      idx_q       <= '0;
      guard_q     <= 1'b0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
    end else begin
      guard_q <= tick;
      if (tick) begin
        ps_q  <= '0;
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end else begin
        ps_q  <= ps_q + 1'b1;
      end

      if (commit) begin
        // A load in the commit cycle bypasses the pending buffer; the pending
        // copy is kept equal to the active one so no stale value survives.
        if (load_i) begin
          act_data_q  <= data_i;
          act_dp_q    <= dp_i;
          pend_data_q <= data_i;
          pend_dp_q   <= dp_i;
        end else begin
          act_data_q  <= pend_data_q;
          act_dp_q    <= pend_dp_q;
        end
        pend_flag_q <= 1'b0;
      end else if (load_i) begin
        pend_data_q <= data_i;
        pend_dp_q   <= dp_i;
        pend_flag_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next output values (active-high)
  // -------------------------------------------------------------------------
  logic [N_DIGITS-1:0] nib_zero;
  logic [N_DIGITS-1:0] zero_from;   // nibbles i..N_DIGITS-1 all zero
  logic                zf;
  logic [3:0]          nib;
  logic                dp_bit;
  logic                lz;
  logic [N_DIGITS-1:0] an_hot;
  logic                show;
  logic [6:0]          seg_nx;
  logic                dp_nx;
  logic [N_DIGITS-1:0] an_nx;

  always_comb begin
    nib_zero  = '0;
    zero_from = '0;
    zf        = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      nib_zero[i] = (act_data_q[i*4 +: 4] == 4'h0);
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      zf = 1'b1;
      for (int j = i; j < N_DIGITS; j++) begin
        zf = zf & nib_zero[j];
      end
      zero_from[i] = zf;
    end
  end

  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    lz     = 1'b0;
    an_hot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = act_data_q[i*4 +: 4];
        dp_bit    = act_dp_q[i];
        // Digit 0 always shows, so a zero value still reads "0".
        lz        = blank_lz_i && (i != 0) && zero_from[i];
        an_hot[i] = 1'b1;
      end
    end
    show   = en_i && !guard_q;
    seg_nx = (show && !lz) ? seg_decode(nib) : 7'h00;
    dp_nx  = show && dp_bit;
    an_nx  = show ? an_hot : '0;
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seg_q   <= {7{POL}};
      dp_q    <= POL;
      an_q    <= {N_DIGITS{POL}};
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_nx ^ {7{POL}};
      dp_q    <= dp_nx ^ POL;
      an_q    <= an_nx ^ {N_DIGITS{POL}};
      frame_q <= commit;
    end
  end

  assign seg_o     = seg_q;
  assign dp_o      = dp_q;
  assign an_o      = an_q;
  assign frame_o   = frame_q;
  assign pending_o = pend_flag_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [15:0] data;
  logic [3:0]  dp;
  logic        load;
  logic        blz;
  logic        en;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;
  logic        pending_o;

  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .dp_i(dp), .load_i(load),
    .blank_lz_i(blz), .en_i(en), .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o),
    .frame_o(frame_o), .pending_o(pending_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: cycle count since reset release plus buffers
  logic [6:0]  seg_tab [16];
  int          mj;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_flag;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_frame;
  logic        e_pend;

  // display capture for frame checks
  logic [6:0]  rec_seg [4];
  logic        rec_dp  [4];
  int          sc;
  int          last_f;

  task automatic model_reset();
    mj = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_flag = 1'b0;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_frame = 1'b0; e_pend = 1'b0;
    last_f = -1;
  endtask

  // Outputs after an edge reflect the cycle count before it: slot = count/RD,
  // the first cycle of every slot after the first is dark, and the frame
  // boundary is the last cycle of every N*RD block.
  task automatic model_edge();
    int jp, ph, dig;
    logic off, blank, commit;
    logic [3:0] nib;
    jp  = mj;
    ph  = jp % RD;
    dig = (jp / RD) % N;
    off = ((ph == 0) && (jp > 0)) || !en;
    nib = m_act[dig*4 +: 4];
    blank = blz && (dig > 0) && ((m_act >> (dig*4)) == 16'h0);
    if (off) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end else begin
      e_an  = ~(4'b0001 << dig);
      e_seg = blank ? 7'h7F : seg_tab[nib];
      e_dp  = ~m_act_dp[dig];
    end
    commit  = (jp % (RD*N)) == (RD*N - 1);
    e_frame = commit;
    if (commit) begin
      if (load) begin
        m_act = data; m_act_dp = dp; m_pend = data; m_pend_dp = dp;
      end else begin
        m_act = m_pend; m_act_dp = m_pend_dp;
      end
      m_flag = 1'b0;
    end else if (load) begin
      m_pend = data; m_pend_dp = dp; m_flag = 1'b1;
    end
    e_pend = m_flag;
    mj++;
  endtask

  // driver: one clock, inputs already set at the preceding negedge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    sc++;
    check("seg", 32'(seg_o), 32'(e_seg));
    check("dp", 32'(dp_o), 32'(e_dp));
    check("an", 32'(an_o), 32'(e_an));
    check("frame", 32'(frame_o), 32'(e_frame));
    check("pending", 32'(pending_o), 32'(e_pend));
    if (frame_o) begin
      if (last_f >= 0) check("frame_period", 32'(sc - last_f), 32'(RD*N));
      last_f = sc;
    end
    for (int d = 0; d < N; d++) begin
      if (an_o[d] == 1'b0) begin
        rec_seg[d] = seg_o;
        rec_dp[d]  = dp_o;
      end
    end
  endtask

  task automatic clear_rec();
    for (int d = 0; d < N; d++) begin
      rec_seg[d] = 7'h55;
      rec_dp[d]  = 1'bx;
    end
  endtask

  task automatic check_off(input string name);
    check({name, "_seg"}, 32'(seg_o), 32'h7F);
    check({name, "_dp"}, 32'(dp_o), 32'h1);
    check({name, "_an"}, 32'(an_o), 32'hF);
    check({name, "_frame"}, 32'(frame_o), 32'h0);
    check({name, "_pend"}, 32'(pending_o), 32'h0);
  endtask

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][6:0] seg;   // {digit3, digit2, digit1, digit0}
    logic [3:0]      dpo;   // dp_o level per digit
  } vec_t;

  vec_t tab [8];

  task automatic compare_rec(input int k);
    for (int d = 0; d < N; d++) begin
      check($sformatf("vec%0d_seg_d%0d", k, d), 32'(rec_seg[d]), 32'(tab[k].seg[d]));
      check($sformatf("vec%0d_dp_d%0d", k, d), 32'(rec_dp[d]), 32'(tab[k].dpo[d]));
    end
  endtask

  // load, wait for the commit, then capture one full frame
  task automatic load_and_show(input int k);
    int n;
    data = tab[k].data; dp = tab[k].dp; blz = tab[k].blz; load = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (!e_frame && n < 40) begin
      step();
      n++;
    end
    if (!e_frame) check("commit_timeout", 32'(n), 32'(0));
    clear_rec();
    repeat (RD*N) step();
    compare_rec(k);
  endtask

  initial begin
    int n, fcount, seen_bad;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    tab[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
    tab[1] = '{16'h0040, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1111};
    tab[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    tab[3] = '{16'hBEEF, 4'b0000, 1'b0, {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b1111};
    tab[4] = '{16'h0007, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b1111};
    tab[5] = '{16'h0305, 4'b1000, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h12}, 4'b0111};
    tab[6] = '{16'h8000, 4'b0001, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40}, 4'b1110};
    tab[7] = '{16'hC9D6, 4'b0000, 1'b0, {7'h46, 7'h18, 7'h21, 7'h02}, 4'b1111};

    sc = 0;
    rst = 1'b1; data = '0; dp = '0; load = 1'b0; blz = 1'b0; en = 1'b1;
    model_reset();
    @(negedge clk);
    check_off("reset");
    @(negedge clk);
    rst = 1'b0;

    // first frame shows 0000, second frame shows the loaded value
    for (int k = 0; k < 8; k++) load_and_show(k);

    // two loads in one frame: last wins, pending held until the wrap
    while (mj % (RD*N) != 4) step();
    data = 16'h0001; dp = '0; blz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    data = 16'h0007; load = 1'b1;
    step();
    load = 1'b0;
    n = 0; fcount = 0; seen_bad = 0;
    while (n < 40) begin
      step();
      n++;
      if (frame_o) fcount++;
      if (e_frame) break;
      check("pend_hold", 32'(pending_o), 32'h1);
    end
    check("two_load_frames", 32'(fcount), 32'h1);
    clear_rec();
    repeat (RD*N) begin
      step();
      if (an_o == 4'b1110 && seg_o == 7'h79) seen_bad++;
    end
    check("stale_0001_shown", 32'(seen_bad), 32'h0);
    compare_rec(4);

    // load in the commit cycle goes straight to active
    data = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    while (mj % (RD*N) != RD*N - 1) step();
    data = 16'hBEEF; dp = '0; load = 1'b1;
    step();
    load = 1'b0;
    check("bypass_pend", 32'(pending_o), 32'h0);
    check("bypass_frame", 32'(frame_o), 32'h1);
    clear_rec();
    repeat (RD*N) step();
    compare_rec(3);

    // disable for 10 cycles; scan phase and frame period continue
    while (mj % RD != 2) step();
    en = 1'b0;
    repeat (10) begin
      step();
      check("disabled_an", 32'(an_o), 32'hF);
    end
    en = 1'b1;
    repeat (40) step();

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 7) == 0);
      data = 16'($urandom);
      dp   = 4'($urandom_range(0, 15));
      blz  = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 9) != 0);
      step();
    end
    load = 1'b0; en = 1'b1; blz = 1'b0;

    // asynchronous reset mid-slot with data pending
    while (mj % (RD*N) != 5) step();
    data = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    step();
    check("pre_reset_pend", 32'(pending_o), 32'h1);
    #2 rst = 1'b1;
    #1 check_off("async_reset");
    @(negedge clk);
    check_off("held_reset");
    rst = 1'b0;
    model_reset();
    step();
    check("post_reset_an", 32'(an_o), 32'hE);
    check("post_reset_seg", 32'(seg_o), 32'h40);
    n = 1;
    while (an_o != 4'hF && n < 10) begin
      step();
      n++;
    end
    check("first_guard_step", 32'(n), 32'd5);
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
